// File: rtl/bf16_sched_pkg.sv
// Shared defaults and types for the bf16 multiplier scheduler.
package bf16_sched_pkg;

    localparam int NUM_REQ_DEFAULT = 4;
    localparam int MUL_LAT_DEFAULT = 1;

    typedef logic [15:0] bf16_t;
    typedef logic [$clog2(NUM_REQ_DEFAULT)-1:0] req_id_t;

    localparam bf16_t BF16_ZERO = 16'h0000;

endpackage

// File: rtl/bf16_mul_sched_rr_arbiter.sv
// Round-robin arbiter: grants the first requester found searching upward from ptr_i.
module rr_arbiter #(
    parameter  int N   = 4,
    localparam int IdW = $clog2(N)
) (
    input  logic [N-1:0]   req_i,
    input  logic [IdW-1:0] ptr_i,
    output logic [N-1:0]   gnt_o,
    output logic [IdW-1:0] idx_o
);

    always_comb begin
        int   cand;
        logic found;
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        cand  = 0;
        for (int k = 0; k < N; k++) begin
            cand = int'(ptr_i) + k;
            if (cand >= N) begin
                cand = cand - N;
            end
            if (!found && req_i[cand]) begin
                found       = 1'b1;
                gnt_o[cand] = 1'b1;
                idx_o       = cand[IdW-1:0];
            end
        end
    end

endmodule

// File: rtl/bf16_mul_sched.sv
// Shares one external fixed-latency bf16 multiplier among NUM_REQ requesters,
// routing each product back to its requester's response buffer.
module bf16_mul_sched
    import bf16_sched_pkg::*;
#(
    parameter  int NUM_REQ = NUM_REQ_DEFAULT,
    parameter  int MUL_LAT = MUL_LAT_DEFAULT,
    localparam int IdW     = $clog2(NUM_REQ)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [NUM_REQ-1:0]  req_valid_i,
    output logic [NUM_REQ-1:0]  req_ready_o,
    input  bf16_t [NUM_REQ-1:0] req_a_i,
    input  bf16_t [NUM_REQ-1:0] req_b_i,
    output logic [NUM_REQ-1:0]  rsp_valid_o,
    input  logic [NUM_REQ-1:0]  rsp_ready_i,
    output bf16_t [NUM_REQ-1:0] rsp_data_o,
    output bf16_t               mul_a_o,
    output bf16_t               mul_b_o,
    input  bf16_t               mul_res_i,
    input  logic                flush_i,
    output logic                busy_o
);

    logic [NUM_REQ-1:0]  inFlight_q, inFlight_d;
    logic [NUM_REQ-1:0]  rspValid_q, rspValid_d;
    bf16_t [NUM_REQ-1:0] rspData_q;
    logic [IdW-1:0]      rrPtr_q, rrPtr_d;

    logic [NUM_REQ-1:0]  eligible;
    logic [NUM_REQ-1:0]  grantVec;
    logic [NUM_REQ-1:0]  captureVec;
    logic [IdW-1:0]      grantIdx;
    logic                grantValid;
    logic                tagOutValid;
    logic [IdW-1:0]      tagOutId;

    // Reset and flush both mask the request vector so nothing issues in those cycles.
    assign eligible = req_valid_i & ~(inFlight_q | rspValid_q)
                    & {NUM_REQ{rst_ni & ~flush_i}};

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .req_i (eligible),
        .ptr_i (rrPtr_q),
        .gnt_o (grantVec),
        .idx_o (grantIdx)
    );

    assign grantValid  = |grantVec;
    assign req_ready_o = grantVec;
    assign mul_a_o     = grantValid ? req_a_i[grantIdx] : BF16_ZERO;
    assign mul_b_o     = grantValid ? req_b_i[grantIdx] : BF16_ZERO;

    // The tag pipeline tracks which requester owns the product emerging from the multiplier.
    generate
        if (MUL_LAT == 0) begin : g_no_pipe
            assign tagOutValid = grantValid;
            assign tagOutId    = grantIdx;
        end else begin : g_pipe
            logic [MUL_LAT-1:0]          tagValid_q;
            logic [MUL_LAT-1:0][IdW-1:0] tagId_q;

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    tagValid_q <= '0;
                    tagId_q    <= '0;
                end else if (flush_i) begin
                    tagValid_q <= '0;
                end else begin
                    tagValid_q[0] <= grantValid;
                    tagId_q[0]    <= grantIdx;
                    for (int s = 1; s < MUL_LAT; s++) begin
                        tagValid_q[s] <= tagValid_q[s-1];
                        tagId_q[s]    <= tagId_q[s-1];
                    end
                end
            end

            assign tagOutValid = tagValid_q[MUL_LAT-1];
            assign tagOutId    = tagId_q[MUL_LAT-1];
        end
    endgenerate

    always_comb begin
        captureVec = '0;
        if (tagOutValid && !flush_i) begin
            captureVec[tagOutId] = 1'b1;
        end
    end

    always_comb begin
        inFlight_d = (inFlight_q | grantVec) & ~captureVec;
        rspValid_d = (rspValid_q & ~rsp_ready_i) | captureVec;
        rrPtr_d    = rrPtr_q;
        if (grantValid) begin
            rrPtr_d = (grantIdx == IdW'(NUM_REQ - 1)) ? '0 : grantIdx + 1'b1;
        end
        if (flush_i) begin
            inFlight_d = '0;
            rspValid_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            inFlight_q <= '0;
            rspValid_q <= '0;
            rspData_q  <= '0;
            rrPtr_q    <= '0;
        end else begin
            inFlight_q <= inFlight_d;
            rspValid_q <= rspValid_d;
            rrPtr_q    <= rrPtr_d;
            if (tagOutValid && !flush_i) begin
                rspData_q[tagOutId] <= mul_res_i;
            end
        end
    end

    assign rsp_valid_o = rspValid_q;
    assign rsp_data_o  = rspData_q;
    assign busy_o      = (|inFlight_q) | (|rspValid_q);

endmodule

// File: tb/tb_bf16_mul_sched.sv
// Bench for bf16_mul_sched: scoreboarded MUL_LAT=1 instance plus directed checks
// on MUL_LAT=0 and MUL_LAT=2 instances sharing a second stimulus set.
module tb_bf16_mul_sched;

    localparam int NR = 4;

    logic clk = 1'b0;
    logic rstN;
    always #5 clk = ~clk;

    logic [NR-1:0]       reqValid, reqReady, rspValid, rspReady;
    logic [NR-1:0][15:0] reqA, reqB, rspData;
    logic [15:0]         mulA, mulB, mulRes;
    logic                flush, busy;

    logic [NR-1:0]       auxValid, auxRspReady;
    logic [NR-1:0][15:0] auxA, auxB;
    logic                auxFlush;
    logic [NR-1:0]       reqReady0, rspValid0, reqReady2, rspValid2;
    logic [NR-1:0][15:0] rspData0, rspData2;
    logic [15:0]         mulA0, mulB0, mulRes0, mulA2, mulB2, mulRes2, mulStage2;
    logic                busy0, busy2;

    int compared   = 0;
    int mismatched = 0;
    logic [15:0] expQ [NR][$];

    // Reference bf16 multiply for finite normal operands, round to nearest even.
    function automatic logic [15:0] bf16Mul(input logic [15:0] a, input logic [15:0] b);
        logic        sgn;
        int          e;
        logic [15:0] p;
        logic [7:0]  m;
        logic        g, st;
        sgn = a[15] ^ b[15];
        if (a[14:0] == 15'h0 || b[14:0] == 15'h0) return {sgn, 15'h0};
        p = {8'h0, 1'b1, a[6:0]} * {8'h0, 1'b1, b[6:0]};
        e = int'(a[14:7]) + int'(b[14:7]) - 127;
        if (p[15]) begin
            m = p[15:8]; g = p[7]; st = |p[6:0]; e = e + 1;
        end else begin
            m = p[14:7]; g = p[6]; st = |p[5:0];
        end
        if (g && (st || m[0])) begin
            if (m == 8'hFF) begin
                m = 8'h80; e = e + 1;
            end else begin
                m = m + 8'd1;
            end
        end
        return {sgn, e[7:0], m[6:0]};
    endfunction

    bf16_mul_sched #(.NUM_REQ(NR), .MUL_LAT(1)) dut (
        .clk_i(clk), .rst_ni(rstN),
        .req_valid_i(reqValid), .req_ready_o(reqReady),
        .req_a_i(reqA), .req_b_i(reqB),
        .rsp_valid_o(rspValid), .rsp_ready_i(rspReady), .rsp_data_o(rspData),
        .mul_a_o(mulA), .mul_b_o(mulB), .mul_res_i(mulRes),
        .flush_i(flush), .busy_o(busy)
    );

    bf16_mul_sched #(.NUM_REQ(NR), .MUL_LAT(0)) dut0 (
        .clk_i(clk), .rst_ni(rstN),
        .req_valid_i(auxValid), .req_ready_o(reqReady0),
        .req_a_i(auxA), .req_b_i(auxB),
        .rsp_valid_o(rspValid0), .rsp_ready_i(auxRspReady), .rsp_data_o(rspData0),
        .mul_a_o(mulA0), .mul_b_o(mulB0), .mul_res_i(mulRes0),
        .flush_i(auxFlush), .busy_o(busy0)
    );

    bf16_mul_sched #(.NUM_REQ(NR), .MUL_LAT(2)) dut2 (
        .clk_i(clk), .rst_ni(rstN),
        .req_valid_i(auxValid), .req_ready_o(reqReady2),
        .req_a_i(auxA), .req_b_i(auxB),
        .rsp_valid_o(rspValid2), .rsp_ready_i(auxRspReady), .rsp_data_o(rspData2),
        .mul_a_o(mulA2), .mul_b_o(mulB2), .mul_res_i(mulRes2),
        .flush_i(auxFlush), .busy_o(busy2)
    );

    // Shared multipliers with latencies 1, 0 and 2.
    always @(posedge clk) mulRes <= bf16Mul(mulA, mulB);
    assign mulRes0 = bf16Mul(mulA0, mulB0);
    always @(posedge clk) begin
        mulStage2 <= bf16Mul(mulA2, mulB2);
        mulRes2   <= mulStage2;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [NR-1:0] valid, input logic [NR-1:0] rdy);
        @(posedge clk); #1;
        reqValid = valid;
        rspReady = rdy;
        @(negedge clk);
    endtask

    task automatic applyAux(input logic [NR-1:0] valid, input logic fl);
        @(posedge clk); #1;
        auxValid = valid;
        auxFlush = fl;
        @(negedge clk);
    endtask

    // Scoreboard: push expected product on request handshake, pop on response handshake.
    always @(negedge clk) begin
        if (!rstN) begin
            for (int i = 0; i < NR; i++) expQ[i].delete();
        end else begin
            for (int i = 0; i < NR; i++) begin
                if (rspValid[i] && rspReady[i]) begin
                    if (expQ[i].size() == 0)
                        checkOutput($sformatf("sb_unexpected_rsp%0d", i), 32'(rspValid[i]), 32'(0));
                    else
                        checkOutput($sformatf("sb_rsp%0d", i), 32'(rspData[i]),
                                    32'(expQ[i].pop_front()));
                end
                if (reqValid[i] && reqReady[i]) expQ[i].push_back(bf16Mul(reqA[i], reqB[i]));
            end
        end
    end

    initial begin
        logic [NR-1:0] oneHot;
        int left;
        rstN = 1'b1; flush = 1'b0; reqValid = '1; rspReady = '0;
        reqA = {16'hBF80, 16'h4040, 16'h3FC0, 16'h3F80};
        reqB = {16'h4080, 16'h3F00, 16'h4000, 16'h4000};
        auxValid = '0; auxRspReady = '0; auxA = '0; auxB = '0; auxFlush = 1'b0;
        #1 rstN = 1'b0;
        #2;
        checkOutput("rst_ready", 32'(reqReady), 32'(0));
        checkOutput("rst_mulA", 32'(mulA), 32'(0));
        checkOutput("rst_mulB", 32'(mulB), 32'(0));
        checkOutput("rst_rspValid", 32'(rspValid), 32'(0));
        checkOutput("rst_busy", 32'(busy), 32'(0));

        // Round-robin with all four requesters continuously valid.
        for (int k = 0; k < 5; k++) begin
            if (k == 0) begin
                @(posedge clk); #1;
                rstN = 1'b1; rspReady = '1;
                @(negedge clk);
            end else begin
                applyStimulus(4'hF, 4'hF);
            end
            oneHot = NR'(1) << (k % NR);
            checkOutput($sformatf("rr_grant%0d", k), 32'(reqReady), 32'(oneHot));
            checkOutput($sformatf("rr_mulA%0d", k), 32'(mulA), 32'(reqA[k % NR]));
        end
        for (int k = 0; k < 4; k++) applyStimulus(4'h0, 4'hF);
        checkOutput("rr_drain_busy", 32'(busy), 32'(0));

        // Single op on requester 0: 1.0 * 2.0.
        applyStimulus(4'b0001, 4'b0000);
        checkOutput("one_ready", 32'(reqReady), 32'(4'b0001));
        checkOutput("one_mulA", 32'(mulA), 32'(16'h3F80));
        checkOutput("one_mulB", 32'(mulB), 32'(16'h4000));
        applyStimulus(4'b0000, 4'b0000);
        checkOutput("one_rspValid_early", 32'(rspValid), 32'(0));
        checkOutput("one_busy", 32'(busy), 32'(1));
        applyStimulus(4'b0000, 4'b0000);
        checkOutput("one_rspValid", 32'(rspValid), 32'(4'b0001));
        checkOutput("one_rspData", 32'(rspData[0]), 32'(16'h4000));
        applyStimulus(4'b0000, 4'b0001);
        applyStimulus(4'b0000, 4'b0000);
        checkOutput("one_rspValid_clr", 32'(rspValid), 32'(0));
        checkOutput("one_busy_clr", 32'(busy), 32'(0));

        // Requester 1 response backpressured: data held, no re-grant until handshake.
        applyStimulus(4'b0010, 4'b0000);
        checkOutput("bp_ready", 32'(reqReady), 32'(4'b0010));
        applyStimulus(4'b0010, 4'b0000);
        checkOutput("bp_inflight_ready", 32'(reqReady), 32'(0));
        for (int k = 0; k < 5; k++) begin
            applyStimulus(4'b0010, 4'b0000);
            checkOutput($sformatf("bp_valid%0d", k), 32'(rspValid), 32'(4'b0010));
            checkOutput($sformatf("bp_data%0d", k), 32'(rspData[1]), 32'(16'h4040));
            checkOutput($sformatf("bp_noregrant%0d", k), 32'(reqReady), 32'(0));
        end
        applyStimulus(4'b0010, 4'b0010);
        checkOutput("bp_hs_ready", 32'(reqReady), 32'(0));
        applyStimulus(4'b0010, 4'b0000);
        checkOutput("bp_regrant", 32'(reqReady), 32'(4'b0010));
        for (int k = 0; k < 3; k++) applyStimulus(4'b0000, 4'b0010);
        checkOutput("bp_drain_busy", 32'(busy), 32'(0));

        // Reset in the middle of a busy stream.
        for (int k = 0; k < 3; k++) applyStimulus(4'hF, 4'hF);
        @(posedge clk); #1;
        rstN = 1'b0;
        #1;
        checkOutput("mrst_ready", 32'(reqReady), 32'(0));
        checkOutput("mrst_mulA", 32'(mulA), 32'(0));
        checkOutput("mrst_rspValid", 32'(rspValid), 32'(0));
        checkOutput("mrst_busy", 32'(busy), 32'(0));
        for (int i = 0; i < NR; i++)
            checkOutput($sformatf("mrst_rspData%0d", i), 32'(rspData[i]), 32'(0));
        @(posedge clk); #1;
        rstN = 1'b1;
        @(negedge clk);
        checkOutput("mrst_first_grant", 32'(reqReady), 32'(4'b0001));
        for (int k = 0; k < 4; k++) applyStimulus(4'h0, 4'hF);
        checkOutput("mrst_drain_busy", 32'(busy), 32'(0));
        left = 0;
        for (int i = 0; i < NR; i++) left += expQ[i].size();
        checkOutput("sb_drained", 32'(left), 32'(0));

        // Zero-latency multiplier: -1.0 * 3.0 on requester 2.
        auxA[2] = 16'hBF80; auxB[2] = 16'h4040;
        applyAux(4'b0100, 1'b0);
        checkOutput("lat0_ready", 32'(reqReady0), 32'(4'b0100));
        checkOutput("lat0_mulA", 32'(mulA0), 32'(16'hBF80));
        checkOutput("lat0_mulB", 32'(mulB0), 32'(16'h4040));
        applyAux(4'b0000, 1'b0);
        checkOutput("lat0_rspValid", 32'(rspValid0), 32'(4'b0100));
        checkOutput("lat0_rspData", 32'(rspData0[2]), 32'(16'hC040));
        checkOutput("lat0_busy", 32'(busy0), 32'(1));
        applyAux(4'b0000, 1'b1);
        applyAux(4'b0000, 1'b0);

        // Flush with two ops in flight on the two-stage pipeline instance.
        auxA[0] = 16'h3F80; auxB[0] = 16'h4000;
        auxA[1] = 16'h3FC0; auxB[1] = 16'h4000;
        auxA[3] = 16'h4000; auxB[3] = 16'h4000;
        applyAux(4'b0011, 1'b0);
        checkOutput("fl_grant0", 32'(reqReady2), 32'(4'b0001));
        applyAux(4'b0011, 1'b0);
        checkOutput("fl_grant1", 32'(reqReady2), 32'(4'b0010));
        applyAux(4'b1000, 1'b1);
        checkOutput("fl_nogrant", 32'(reqReady2), 32'(0));
        checkOutput("fl_busy_before", 32'(busy2), 32'(1));
        checkOutput("fl_rspValid_a", 32'(rspValid2), 32'(0));
        applyAux(4'b1111, 1'b0);
        checkOutput("fl_busy_after", 32'(busy2), 32'(0));
        checkOutput("fl_rspValid_b", 32'(rspValid2), 32'(0));
        checkOutput("fl_ptr_kept", 32'(reqReady2), 32'(4'b0100));
        applyAux(4'b0000, 1'b0);
        checkOutput("fl_rspValid_c", 32'(rspValid2), 32'(0));
        applyAux(4'b0000, 1'b1);
        applyAux(4'b0000, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
